// File: rtl/ball_physics.sv
// Pong ball motion engine: frame-stepped ball position with wall and paddle
// reflection, miss detection and a SERVE/PLAY scoring state machine.
module ball_physics #(
  parameter logic [15:0] STEP_X        = 16'd4,
  parameter logic [15:0] STEP_Y        = 16'd3,
  parameter logic [15:0] BALL_SIZE     = 16'd8,
  parameter logic [15:0] PADDLE_HEIGHT = 16'd100,
  parameter logic [15:0] PADDLE_WIDTH  = 16'd10,
  parameter logic [7:0]  SERVE_DELAY   = 8'd60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic [31:0] dimensions,
  input  logic [31:0] leftPaddle,
  input  logic [31:0] rightPaddle,
  output logic [31:0] ballPosition,
  output logic        in_play,
  output logic        hit,
  output logic        score_left,
  output logic        score_right
);

  typedef enum logic {
    ST_SERVE = 1'b0,
    ST_PLAY  = 1'b1
  } state_t;

  localparam logic signed [16:0] STEP_X_S  = $signed({1'b0, STEP_X});
  localparam logic signed [16:0] BALL_S    = $signed({1'b0, BALL_SIZE});
  localparam logic signed [16:0] PWIDTH_S  = $signed({1'b0, PADDLE_WIDTH});
  localparam logic [16:0]        STEP_Y_U  = {1'b0, STEP_Y};
  localparam logic [16:0]        BALL_U    = {1'b0, BALL_SIZE};
  localparam logic [16:0]        PHEIGHT_U = {1'b0, PADDLE_HEIGHT};

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_x;
  logic [15:0] r_y;
  logic        r_dir_x;
  logic        r_dir_y;
  logic [7:0]  r_cnt;
  logic        r_hit;
  logic        r_score_l;
  logic        r_score_r;

  logic [15:0] w_x_nxt;
  logic [15:0] w_y_nxt;
  logic        w_dir_x_nxt;
  logic        w_dir_y_nxt;
  logic [7:0]  w_cnt_nxt;
  logic        w_hit_nxt;
  logic        w_score_l_nxt;
  logic        w_score_r_nxt;

  logic [15:0] w_width;
  logic [15:0] w_height;
  logic [15:0] w_lp_x;
  logic [15:0] w_lp_y;
  logic [15:0] w_rp_x;
  logic [15:0] w_rp_y;

  assign w_width  = dimensions[31:16];
  assign w_height = dimensions[15:0];
  assign w_lp_x   = leftPaddle[31:16];
  assign w_lp_y   = leftPaddle[15:0];
  assign w_rp_x   = rightPaddle[31:16];
  assign w_rp_y   = rightPaddle[15:0];

  // Vertical geometry, unsigned 17-bit so y+STEP_Y cannot wrap.
  logic [16:0] w_y_u;
  logic [16:0] w_limit;
  logic [16:0] w_y_dn;
  logic [16:0] w_ball_bot;
  logic        w_y_top_hit;
  logic        w_y_bot_hit;

  assign w_y_u       = {1'b0, r_y};
  assign w_limit     = {1'b0, w_height} - BALL_U;
  assign w_y_dn      = w_y_u + STEP_Y_U;
  assign w_ball_bot  = w_y_u + BALL_U - 17'd1;
  assign w_y_top_hit = (w_y_u < STEP_Y_U);
  assign w_y_bot_hit = (w_y_dn >= w_limit);

  // Paddle row overlap against the pre-update ball rows.
  logic w_ovl_l;
  logic w_ovl_r;

  assign w_ovl_l = (w_y_u <= ({1'b0, w_lp_y} + PHEIGHT_U - 17'd1)) &&
                   (w_ball_bot >= {1'b0, w_lp_y});
  assign w_ovl_r = (w_y_u <= ({1'b0, w_rp_y} + PHEIGHT_U - 17'd1)) &&
                   (w_ball_bot >= {1'b0, w_rp_y});

  // Horizontal geometry, signed 17-bit so a face near zero compares correctly.
  logic signed [16:0] w_x_s;
  logic signed [16:0] w_x_lstep;
  logic signed [16:0] w_x_rstep;
  logic signed [16:0] w_face_l;
  logic signed [16:0] w_face_r;
  logic signed [16:0] w_edge_r;
  logic               w_cross_l;
  logic               w_cross_r;
  logic               w_miss_l;
  logic               w_miss_r;

  assign w_x_s     = $signed({1'b0, r_x});
  assign w_x_lstep = w_x_s - STEP_X_S;
  assign w_x_rstep = w_x_s + STEP_X_S;
  assign w_face_l  = $signed({1'b0, w_lp_x}) + PWIDTH_S;
  assign w_face_r  = $signed({1'b0, w_rp_x}) - BALL_S;
  assign w_edge_r  = $signed({1'b0, w_width}) - BALL_S;
  assign w_cross_l = (w_x_s > w_face_l) && (w_x_lstep <= w_face_l);
  assign w_cross_r = (w_x_s < w_face_r) && (w_x_rstep >= w_face_r);
  assign w_miss_l  = (r_x < STEP_X);
  assign w_miss_r  = (w_x_rstep >= w_edge_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SERVE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_dir_x_nxt   = r_dir_x;
    w_dir_y_nxt   = r_dir_y;
    w_cnt_nxt     = r_cnt;
    w_hit_nxt     = 1'b0;
    w_score_l_nxt = 1'b0;
    w_score_r_nxt = 1'b0;

    case (r_state)
      ST_SERVE: begin
        w_x_nxt = w_width >> 1;
        w_y_nxt = w_height >> 1;
        if (frame_tick) begin
          if (r_cnt == SERVE_DELAY) begin
            w_cnt_nxt   = 8'd0;
            w_dir_y_nxt = 1'b1;
            w_state_nxt = ST_PLAY;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end

      ST_PLAY: begin
        if (frame_tick) begin
          if (!r_dir_y) begin
            if (w_y_top_hit) begin
              w_y_nxt     = 16'd0;
              w_dir_y_nxt = 1'b1;
            end else begin
              w_y_nxt = r_y - STEP_Y;
            end
          end else begin
            if (w_y_bot_hit) begin
              w_y_nxt     = w_limit[15:0];
              w_dir_y_nxt = 1'b0;
            end else begin
              w_y_nxt = w_y_dn[15:0];
            end
          end

          // A score discards this tick's vertical move; SERVE recentres next clock.
          if (!r_dir_x) begin
            if (w_cross_l && w_ovl_l) begin
              w_x_nxt     = w_face_l[15:0];
              w_dir_x_nxt = 1'b1;
              w_hit_nxt   = 1'b1;
            end else if (w_miss_l) begin
              w_score_r_nxt = 1'b1;
              w_dir_x_nxt   = 1'b0;
              w_y_nxt       = r_y;
              w_dir_y_nxt   = r_dir_y;
              w_state_nxt   = ST_SERVE;
            end else begin
              w_x_nxt = r_x - STEP_X;
            end
          end else begin
            if (w_cross_r && w_ovl_r) begin
              w_x_nxt     = w_face_r[15:0];
              w_dir_x_nxt = 1'b0;
              w_hit_nxt   = 1'b1;
            end else if (w_miss_r) begin
              w_score_l_nxt = 1'b1;
              w_dir_x_nxt   = 1'b1;
              w_y_nxt       = r_y;
              w_dir_y_nxt   = r_dir_y;
              w_state_nxt   = ST_SERVE;
            end else begin
              w_x_nxt = r_x + STEP_X;
            end
          end
        end
      end

      default: begin
        w_state_nxt = ST_SERVE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x       <= 16'd0;
      r_y       <= 16'd0;
      r_dir_x   <= 1'b1;
      r_dir_y   <= 1'b1;
      r_cnt     <= 8'd0;
      r_hit     <= 1'b0;
      r_score_l <= 1'b0;
      r_score_r <= 1'b0;
    end else begin
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_dir_x   <= w_dir_x_nxt;
      r_dir_y   <= w_dir_y_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hit     <= w_hit_nxt;
      r_score_l <= w_score_l_nxt;
      r_score_r <= w_score_r_nxt;
    end
  end

  assign ballPosition = {r_x, r_y};
  assign in_play      = (r_state == ST_PLAY);
  assign hit          = r_hit;
  assign score_left   = r_score_l;
  assign score_right  = r_score_r;

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics: serve timing, wall clamps, paddle hits,
// misses and scoring, with hand-computed positions checked by assertions.
module tb_ball_physics;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic [31:0] dimensions;
  logic [31:0] leftPaddle;
  logic [31:0] rightPaddle;
  logic [31:0] ballPosition;
  logic        in_play;
  logic        hit;
  logic        score_left;
  logic        score_right;

  int n_checks;
  int n_errors;

  ball_physics #(
    .SERVE_DELAY(8'd2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .dimensions  (dimensions),
    .leftPaddle  (leftPaddle),
    .rightPaddle (rightPaddle),
    .ballPosition(ballPosition),
    .in_play     (in_play),
    .hit         (hit),
    .score_left  (score_left),
    .score_right (score_right)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Flags packed as {hit, score_left, score_right, in_play}.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [3:0] exp);
    chk(tag, {28'd0, hit, score_left, score_right, in_play}, {28'd0, exp});
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic serve3();
    tick();
    tick();
    tick();
  endtask

  logic [15:0] ex;
  logic [15:0] ey;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    frame_tick  = 1'b0;
    dimensions  = 32'h0280_01E0;
    leftPaddle  = 32'h000A_0050;
    rightPaddle = 32'h0270_00C8;
    repeat (3) @(negedge clk);
    chk("rst_pos", ballPosition, 32'h0000_0000);
    chk_flags("rst_flags", 4'b0000);

    // Tick on the first clock after release counts as a serve tick.
    rst        = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("serve_pos1", ballPosition, 32'h0140_00F0);
    chk_flags("serve_flags1", 4'b0000);
    tick();
    chk("serve_pos2", ballPosition, 32'h0140_00F0);
    chk_flags("serve_flags2", 4'b0000);
    tick();
    chk("serve_pos3", ballPosition, 32'h0140_00F0);
    chk_flags("serve_flags3", 4'b0001);

    // Hold between ticks, one step, then async reset mid-play.
    repeat (2) @(negedge clk);
    chk("hold_pos", ballPosition, 32'h0140_00F0);
    tick();
    chk("play_step", ballPosition, 32'h0144_00F3);
    chk_flags("play_flags", 4'b0001);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_pos", ballPosition, 32'h0000_0000);
    chk_flags("async_rst_flags", 4'b0000);
    @(negedge clk);
    rst = 1'b0;

    // Bottom wall clamp at limit 472.
    dimensions = 32'h0280_03A6;
    @(negedge clk);
    chk("centre_track", ballPosition, 32'h0140_01D3);
    serve3();
    chk("c_serve_pos", ballPosition, 32'h0140_01D3);
    chk_flags("c_serve_flags", 4'b0001);
    dimensions = 32'h0280_01E0;
    tick();
    chk("y_470", ballPosition, 32'h0144_01D6);
    tick();
    chk("y_clamp_472", ballPosition, 32'h0148_01D8);
    tick();
    chk("y_up_469", ballPosition, 32'h014C_01D5);

    // Right paddle hit at face 616, then right miss and score_left.
    do_reset();
    dimensions = 32'h04CC_0190;
    serve3();
    chk("d_serve_pos", ballPosition, 32'h0266_00C8);
    chk_flags("d_serve_flags", 4'b0001);
    tick();
    chk("r_hit_pos", ballPosition, 32'h0268_00CB);
    chk_flags("r_hit_flags", 4'b1001);
    @(negedge clk);
    chk_flags("r_hit_clear", 4'b0001);
    tick();
    chk("r_hit_back", ballPosition, 32'h0264_00CE);
    leftPaddle = 32'h0256_00C8;
    tick();
    chk("l_hit_608", ballPosition, 32'h0260_00D1);
    chk_flags("l_hit_608_flags", 4'b1001);
    rightPaddle = 32'h0270_0300;
    dimensions  = 32'h0278_0190;
    tick();
    chk("r_walk_612", ballPosition, 32'h0264_00D4);
    tick();
    chk("r_miss_cross", ballPosition, 32'h0268_00D7);
    chk_flags("r_miss_cross_flags", 4'b0001);
    tick();
    chk("r_walk_620", ballPosition, 32'h026C_00DA);
    tick();
    chk("score_l_pos", ballPosition, 32'h026C_00DA);
    chk_flags("score_l_flags", 4'b0100);
    @(negedge clk);
    chk("score_l_recentre", ballPosition, 32'h013C_00C8);
    chk_flags("score_l_clear", 4'b0000);

    // Small field: bounce between paddles, then left miss and score_right.
    dimensions  = 32'h0030_00C8;
    leftPaddle  = 32'h000A_0050;
    rightPaddle = 32'h0024_0064;
    serve3();
    chk("e_serve_pos", ballPosition, 32'h0018_0064);
    chk_flags("e_serve_flags", 4'b0001);
    tick();
    chk("e_rhit", ballPosition, 32'h001C_0067);
    chk_flags("e_rhit_flags", 4'b1001);
    tick();
    chk("e_left_24", ballPosition, 32'h0018_006A);
    tick();
    chk("e_lhit", ballPosition, 32'h0014_006D);
    chk_flags("e_lhit_flags", 4'b1001);
    tick();
    chk("e_right_24", ballPosition, 32'h0018_0070);
    tick();
    chk("e_rhit2", ballPosition, 32'h001C_0073);
    chk_flags("e_rhit2_flags", 4'b1001);
    leftPaddle = 32'h000A_0100;
    tick();
    chk("e_left_24b", ballPosition, 32'h0018_0076);
    tick();
    chk("l_miss_cross", ballPosition, 32'h0014_0079);
    chk_flags("l_miss_cross_flags", 4'b0001);
    // Paddle moves back into the ball after the crossing: must not hit.
    leftPaddle = 32'h000A_0050;
    for (int i = 1; i <= 5; i++) begin
      tick();
      ex = 16'(20 - 4 * i);
      ey = 16'(121 + 3 * i);
      chk("miss_walk_pos", ballPosition, {ex, ey});
      chk_flags("miss_walk_flags", 4'b0001);
    end
    tick();
    chk("score_r_pos", ballPosition, 32'h0000_0088);
    chk_flags("score_r_flags", 4'b0010);
    @(negedge clk);
    chk("score_r_recentre", ballPosition, 32'h0018_0064);
    chk_flags("score_r_clear", 4'b0000);

    // Serve after score_right heads left into the paddle.
    serve3();
    chk("f_serve_pos", ballPosition, 32'h0018_0064);
    tick();
    chk("f_lhit", ballPosition, 32'h0014_0067);
    chk_flags("f_lhit_flags", 4'b1001);
    tick();
    chk("f_right_24", ballPosition, 32'h0018_006A);

    // Shrink height to limit 5: bottom clamp, then top clamp at 0.
    rightPaddle = 32'h0024_0300;
    dimensions  = 32'h0040_000D;
    tick();
    chk("f_bot_clamp", ballPosition, 32'h001C_0005);
    tick();
    chk("f_up_2", ballPosition, 32'h0020_0002);
    tick();
    chk("f_top_clamp", ballPosition, 32'h0024_0000);
    tick();
    chk("f_down_3", ballPosition, 32'h0028_0003);
    chk_flags("f_end_flags", 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ball_physics.md
# ball_physics

Ball motion engine for the Pong datapath. It sits directly upstream of the paddle tracker and produces the packed `ballPosition` word that the tracker consumes. On every frame tick it advances the ball by a fixed step, reflects it off the top and bottom walls and off either paddle face, and detects misses. A serve/score state machine recentres the ball after each point.

## Interface

Parameters:
- `STEP_X`, 16'd4: horizontal pixels per frame.
- `STEP_Y`, 16'd3: vertical pixels per frame.
- `BALL_SIZE`, 16'd8: ball edge length in pixels; position is the top-left corner.
- `PADDLE_HEIGHT`, 16'd100: paddle span; covers rows `py .. py+PADDLE_HEIGHT-1`.
- `PADDLE_WIDTH`, 16'd10: paddle thickness in pixels.
- `SERVE_DELAY`, 8'd60: frame ticks spent in SERVE before play.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `frame_tick`, in, 1: one-cycle pulse per video frame.
- `dimensions`, in, 32: {width[31:16], height[15:0]}.
- `leftPaddle`, in, 32: {x[31:16], top y[15:0]} of the left paddle.
- `rightPaddle`, in, 32: {x[31:16], top y[15:0]} of the right paddle.
- `ballPosition`, out, 32: {x[31:16], y[15:0]}, registered.
- `in_play`, out, 1: high while in PLAY.
- `hit`, out, 1: one-cycle pulse on a paddle reflection.
- `score_left`, out, 1: one-cycle pulse when the right player misses.
- `score_right`, out, 1: one-cycle pulse when the left player misses.

## Operation

- State machine has two states, SERVE and PLAY. Direction registers are `dir_x` (0 = left, 1 = right) and `dir_y` (0 = up, 1 = down).
- Reset: state SERVE, `ballPosition`=0, `dir_x`=1, `dir_y`=1, serve counter=0, all pulses 0, `in_play`=0.
- SERVE:
  - Every clock, `ballPosition` <= {width>>1, height>>1}.
  - Each `frame_tick` increments the counter.
  - On the tick where counter == `SERVE_DELAY`, clear the counter and go to PLAY. With `SERVE_DELAY`=0, the first tick exits.
  - `dir_y` resets to 1 on exit.
- PLAY: all updates happen only on `frame_tick`. Between ticks all registers hold.
- Y axis, using 17-bit arithmetic and limit = height − BALL_SIZE:
  - Up: if y < STEP_Y then y'=0 and `dir_y`=1, else y'=y−STEP_Y.
  - Down: if y+STEP_Y >= limit then y'=limit and `dir_y`=0, else y'=y+STEP_Y.
- X axis, left-moving, with face_l = leftPaddle.x + PADDLE_WIDTH:
  - Crossing means x > face_l and x−STEP_X <= face_l, using signed 17-bit arithmetic.
  - On a crossing where the ball rows [y, y+BALL_SIZE−1] overlap the paddle rows: x'=face_l, `dir_x`=1, pulse `hit`.
  - Otherwise, if x < STEP_X: pulse `score_right`, set `dir_x`=0 (next serve goes toward the loser, i.e. left), go to SERVE.
  - Otherwise x'=x−STEP_X.
- X axis, right-moving, mirrored, with face_r = rightPaddle.x − BALL_SIZE:
  - Crossing means x < face_r and x+STEP_X >= face_r.
  - On a hit: x'=face_r, `dir_x`=0.
  - On a miss, if x+STEP_X >= width−BALL_SIZE: pulse `score_left`, set `dir_x`=1, go to SERVE.
- Collision overlap tests use the pre-update y and the paddle inputs sampled on the tick.
- A wall bounce and a paddle hit in the same tick both apply.
- A miss sample is only evaluated on the crossing tick. Later ticks past the face never hit, even if the paddle moves into the ball.
- On a score tick the y update is discarded. The ball recentres from the next clock.
- `in_play` = (state == PLAY).

## Timing

- All outputs are registered. A position update becomes visible the cycle after `frame_tick`.
- `hit` and `score_*` are high for exactly that one cycle.
- In SERVE, centre tracking has one-cycle latency from `dimensions`.
- Asserting `rst` mid-play forces the reset values immediately. No pulse is emitted.
- A `frame_tick` on the first clock after reset release is honoured as a SERVE tick.
- `score_left` and `score_right` are never high together. Neither one coincides with `hit`.

## Test plan

- Reset release, dimensions=0x0280_01E0, SERVE_DELAY=2, 3 ticks → `ballPosition`=0x0140_00F0 throughout; `in_play` rises after the 3rd tick.
- PLAY, ball (320,470), down, height 480 → next tick y=472 (limit), `dir_y`=0; following tick y=469.
- Ball (24,100), left, leftPaddle=0x000A_0050 (face 20), STEP_X=4 → tick: x=20, `hit` pulse, `dir_x`=1; next tick x=24.
- Same, leftPaddle y=0x0100 (miss) → x steps 20,16,…,4,0 with no `hit`; tick at x=0 gives `score_right`, state SERVE, centre recentred next clock, serve `dir_x`=0.
- Right side: rightPaddle=0x0270_00C8 (face 616), ball (614,200), right → x=616, `hit`, `dir_x`=0.
- `rst` asserted mid-PLAY between ticks → `ballPosition`=0 and `in_play`=0 asynchronously; after release the serve sequence restarts.
